// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: column drive, row sync, frame-level debounce with ghost rejection,
// one-cycle press strobe and a 16-bit history of the last four keys.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 2048,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [3:0]  o_kp_col,
  input  logic [3:0]  i_kp_row,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_pressed,
  output logic [15:0] o_value
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [3:0] DebMax = 4'(DEBOUNCE);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [SlotW-1:0] slot_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       kp_col_q;
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_key_q;
  logic             prev_is_key_q;
  logic [3:0]       prev_code_q;
  logic [3:0]       stable_q;
  logic [3:0]       key_q;
  logic             valid_q;
  logic             pressed_q;
  logic [15:0]      value_q;

  logic       sample, frame_end;
  logic [1:0] col_next;
  logic [3:0] low;
  logic [1:0] samp_cnt, samp_row;
  logic [1:0] base_cnt;
  logic [3:0] base_key;
  logic [2:0] tot_cnt;
  logic [1:0] frame_cnt;
  logic [3:0] frame_key;
  logic       res_is_key;
  logic [3:0] res_code;
  logic       same_res;
  logic [3:0] stable_nxt;
  logic       accept_key, accept_none;

  assign sample    = (slot_q == SlotLast);
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign col_next  = col_idx_q + 2'd1;
  assign low       = ~row_sync_q;

  // Low-bit count per sample saturates at 2: anything above one key is a ghost/multi press.
  always_comb begin
    samp_cnt = 2'd0;
    samp_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low[i]) begin
        samp_row = 2'(i);
        if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    base_cnt   = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
    base_key   = (col_idx_q == 2'd0) ? 4'd0 : acc_key_q;
    tot_cnt    = {1'b0, base_cnt} + {1'b0, samp_cnt};
    frame_cnt  = (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];
    frame_key  = (samp_cnt != 2'd0) ? {samp_row, col_idx_q} : base_key;
    res_is_key = (frame_cnt == 2'd1);
    res_code   = res_is_key ? frame_key : 4'd0;
    same_res   = (res_is_key == prev_is_key_q) && (res_code == prev_code_q);
    if (same_res) stable_nxt = (stable_q >= DebMax) ? DebMax : stable_q + 4'd1;
    else          stable_nxt = 4'd1;
    accept_key  = res_is_key && (!pressed_q || (key_q != res_code));
    accept_none = !res_is_key && pressed_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_meta_q <= 4'hf;
      row_sync_q <= 4'hf;
      slot_q     <= '0;
      col_idx_q  <= 2'd0;
      kp_col_q   <= 4'b1110;
      acc_cnt_q  <= 2'd0;
      acc_key_q  <= 4'd0;
    end else begin
      row_meta_q <= i_kp_row;
      row_sync_q <= row_meta_q;
      if (sample) begin
        slot_q    <= '0;
        col_idx_q <= col_next;
        kp_col_q  <= ~(4'b0001 << col_next);
        acc_cnt_q <= frame_cnt;
        acc_key_q <= frame_key;
      end else begin
        slot_q <= slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_is_key_q <= 1'b0;
      prev_code_q   <= 4'd0;
      stable_q      <= 4'd0;
      key_q         <= 4'd0;
      valid_q       <= 1'b0;
      pressed_q     <= 1'b0;
      value_q       <= 16'd0;
    end else begin
      valid_q <= 1'b0;
      if (frame_end) begin
        prev_is_key_q <= res_is_key;
        prev_code_q   <= res_code;
        stable_q      <= stable_nxt;
        if (stable_nxt == DebMax) begin
          if (accept_key) begin
            key_q     <= res_code;
            valid_q   <= 1'b1;
            pressed_q <= 1'b1;
            value_q   <= {value_q[11:0], res_code};
          end else if (accept_none) begin
            pressed_q <= 1'b0;
          end
        end
      end
    end
  end

  assign o_kp_col    = kp_col_q;
  assign o_key       = key_q;
  assign o_key_valid = valid_q;
  assign o_pressed   = pressed_q;
  assign o_value     = value_q;

endmodule
